warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
Per-core controller that time-multiplexes one fetch/decode/execute datapath between NUM_WARPS warps. Each warp keeps its own PC and done flag. The scheduler picks a ready warp round-robin and sequences it through fetch, decode, execute and an optional memory wait, then writes back that warp's next PC. It sits between the core's start/done interface, the instruction fetcher, the decoder, the ALU/branch unit and the LSU.

Parameters:
NUM_WARPS, 4, number of hardware warps scheduled (power of two, >=2)
ADDR_WIDTH, 8, instruction address width in words
WARP_ID_WIDTH, $clog2(NUM_WARPS), width of warp index

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: launch kernel
base_pc  in  ADDR_WIDTH  initial PC for every enabled warp, sampled on start
warp_enable_mask  in  NUM_WARPS  warps participating, sampled on start
fetch_valid  out  1  fetch request for fetch_pc
fetch_pc  out  ADDR_WIDTH  PC of the selected warp
fetch_ready  in  1  fetcher returns fetch_instruction this cycle
fetch_instruction  in  32  fetched instruction word
instruction  out  32  latched instruction driven to the decoder
dec_mem_read  in  1  decoded_mem_read_enable from the decoder
dec_mem_write  in  1  decoded_mem_write_enable from the decoder
dec_finish  in  1  decoded_finish from the decoder
exec_valid  out  1  one-cycle pulse: execute the latched instruction for active_warp
exec_branch_taken  in  1  valid with exec_valid: branch resolved taken
exec_branch_target  in  ADDR_WIDTH  target PC when taken
lsu_start  out  1  one-cycle pulse issuing a memory operation
lsu_done  in  1  LSU completion
active_warp  out  WARP_ID_WIDTH  warp currently owning the datapath
warp_done_mask  out  NUM_WARPS  per-warp finished flags
done  out  1  high while all enabled warps are finished

Behaviour:
- Reset (async, rst_n low): state=IDLE. All PCs=0. warp_done_mask=0. rr_ptr=0. active_warp=0. instruction=0. done=0. fetch_valid/exec_valid/lsu_start=0. Reset mid-operation aborts with no side effects.
- States: IDLE, SELECT, FETCH, DECODE, EXECUTE, MEM_WAIT, UPDATE, DONE.
- IDLE: on start, load every PC from base_pc. Set warp_done_mask = ~warp_enable_mask, go to SELECT. A start pulse in any other state except DONE is ignored.
- SELECT: choose the first warp w with !done[w], searching from rr_ptr upward with wrap-around. Set active_warp=w, go to FETCH. If no such warp exists (including an all-zero enable mask), go to DONE. Cost: 1 cycle.
- FETCH: fetch_valid=1, fetch_pc=pc[active_warp]. Stay until fetch_ready; on fetch_ready, latch instruction, go to DECODE. There is no timeout.
- DECODE: 1 cycle. Decoder outputs are combinational from instruction. If dec_finish: set done[active_warp], go to UPDATE without executing. Else go to EXECUTE.
- EXECUTE: exec_valid=1 for exactly 1 cycle, and branch inputs are sampled that cycle. next_pc = exec_branch_taken ? exec_branch_target : pc+1, modulo 2^ADDR_WIDTH (wraps). If dec_mem_read|dec_mem_write (held from DECODE), pulse lsu_start and go to MEM_WAIT. Else go to UPDATE.
- MEM_WAIT: hold until lsu_done, then go to UPDATE. lsu_done in any other state is ignored.
- UPDATE: if not finished, pc[active_warp]=next_pc. Set rr_ptr=active_warp+1 (wraps), go to SELECT.
- DONE: done=1. On start, relaunch exactly as from IDLE.
- Minimum non-memory instruction: SELECT, FETCH (ready same cycle), DECODE, EXECUTE, UPDATE = 5 cycles.
- fetch_pc and instruction are stable for their whole state. Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (common.sv): scheduler_state_t enum; warp_id_t; instruction_memory_address_t sized by ADDR_WIDTH.
- Sub-module rr_picker: combinational round-robin select (mask, ptr -> index, found). It is reusable by the LSU arbiter.

Test Plan:
- Reset with rst_n low mid-FETCH -> state IDLE and all outputs at reset values immediately; resumes cleanly after a new start.
- start, mask=4'b0000 -> done=1 two cycles after start; fetch_valid never asserted.
- start, base_pc=0x10, mask=4'b1111, fetcher always ready, ALU-only program -> fetch order warp 0,1,2,3,0 with fetch_pc 0x10,0x10,0x10,0x10,0x11; 5 cycles per instruction.
- Warp 1 executes a branch, exec_branch_taken=1, target=0x40 -> warp 1's next fetch_pc=0x40; other warps unaffected.
- Load decoded (dec_mem_read=1), lsu_done delayed 7 cycles -> one lsu_start pulse; no fetch_valid for 7 cycles; then scheduling advances to the next warp.
- mask=4'b0101, each warp hits FINISH on its 3rd instruction -> warp_done_mask goes 0b1010 -> 0b1011 -> 0b1111; done=1; warps 1 and 3 are never fetched.
- PC at 0xFF, no branch -> next fetch_pc=0x00 (wrap).

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler and its round-robin picker.
// Default widths match a 4-warp core with an 8-bit instruction space.
package warp_scheduler_pkg;

  localparam int NUM_WARPS_DEF  = 4;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int WARP_ID_W_DEF  = $clog2(NUM_WARPS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM_WAIT,
    ST_UPDATE,
    ST_DONE
  } scheduler_state_t;

  typedef logic [WARP_ID_W_DEF-1:0] warp_id_t;

  typedef logic [ADDR_WIDTH_DEF-1:0] instruction_memory_address_t;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Combinational round-robin select: first set bit of mask at or
// after ptr, wrapping. Shared with the LSU arbiter.
module rr_picker #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0]     mask,
  input  logic [WARP_ID_WIDTH-1:0] ptr,
  output logic [WARP_ID_WIDTH-1:0] idx,
  output logic                     found
);

  logic [WARP_ID_WIDTH-1:0] cand;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      cand = ptr + WARP_ID_WIDTH'(i);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: round-robin time-multiplexing of one
// fetch/decode/execute datapath across NUM_WARPS warps.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS     = NUM_WARPS_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_pc,
  input  logic [NUM_WARPS-1:0]     warp_enable_mask,
  output logic                     fetch_valid,
  output logic [ADDR_WIDTH-1:0]    fetch_pc,
  input  logic                     fetch_ready,
  input  logic [31:0]              fetch_instruction,
  output logic [31:0]              instruction,
  input  logic                     dec_mem_read,
  input  logic                     dec_mem_write,
  input  logic                     dec_finish,
  output logic                     exec_valid,
  input  logic                     exec_branch_taken,
  input  logic [ADDR_WIDTH-1:0]    exec_branch_target,
  output logic                     lsu_start,
  input  logic                     lsu_done,
  output logic [WARP_ID_WIDTH-1:0] active_warp,
  output logic [NUM_WARPS-1:0]     warp_done_mask,
  output logic                     done
);

  scheduler_state_t state;

  logic [ADDR_WIDTH-1:0]    pc [NUM_WARPS];
  logic [ADDR_WIDTH-1:0]    next_pc;
  logic [WARP_ID_WIDTH-1:0] rr_ptr;
  logic [WARP_ID_WIDTH-1:0] pick_idx;
  logic [NUM_WARPS-1:0]     ready_mask;
  logic                     pick_found;
  logic                     mem_op;

  assign ready_mask = ~warp_done_mask;

  rr_picker #(
    .NUM_WARPS     (NUM_WARPS),
    .WARP_ID_WIDTH (WARP_ID_WIDTH)
  ) u_rr_picker (
    .mask  (ready_mask),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Outputs depend on registered state only.
  assign fetch_valid = (state == ST_FETCH);
  assign exec_valid  = (state == ST_EXECUTE);
  assign lsu_start   = (state == ST_EXECUTE) && mem_op;
  assign done        = (state == ST_DONE);
  assign fetch_pc    = pc[active_warp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      for (int i = 0; i < NUM_WARPS; i++) pc[i] <= '0;
      next_pc        <= '0;
      rr_ptr         <= '0;
      active_warp    <= '0;
      instruction    <= '0;
      warp_done_mask <= '0;
      mem_op         <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_WARPS; i++) pc[i] <= base_pc;
            warp_done_mask <= ~warp_enable_mask;
            rr_ptr         <= '0;
            state          <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick_found) begin
            active_warp <= pick_idx;
            state       <= ST_FETCH;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_FETCH: begin
          if (fetch_ready) begin
            instruction <= fetch_instruction;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          mem_op <= dec_mem_read | dec_mem_write;
          if (dec_finish) begin
            warp_done_mask[active_warp] <= 1'b1;
            state                       <= ST_UPDATE;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          next_pc <= exec_branch_taken ? exec_branch_target
                   : pc[active_warp] + ADDR_WIDTH'(1);
          state   <= mem_op ? ST_MEM_WAIT : ST_UPDATE;
        end
        ST_MEM_WAIT: begin
          if (lsu_done) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (!warp_done_mask[active_warp])
            pc[active_warp] <= next_pc;
          rr_ptr <= active_warp + WARP_ID_WIDTH'(1);
          state  <= ST_SELECT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler with small fetcher, decoder,
// branch and LSU responders.
module tb_warp_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_pc = '0;
  logic [3:0]  warp_enable_mask = '0;
  logic        fetch_valid;
  logic [7:0]  fetch_pc;
  logic        fetch_ready;
  logic [31:0] fetch_instruction = '0;
  logic [31:0] instruction;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_finish;
  logic        exec_valid;
  logic        exec_branch_taken;
  logic [7:0]  exec_branch_target;
  logic        lsu_start;
  logic        lsu_done = 1'b0;
  logic [1:0]  active_warp;
  logic [3:0]  warp_done_mask;
  logic        done;

  logic       ready_on = 1'b0;
  logic       br_en = 1'b0;
  logic [1:0] br_warp = '0;
  logic [7:0] br_target = '0;
  logic       mem_on = 1'b0;
  logic [1:0] mem_warp = '0;
  logic [7:0] mem_pc = '0;
  int         lsu_delay = 0;
  int         lsu_wait = 0;
  int         lsu_pulses = 0;
  int         finish_at = 0;
  int         fcount [4];
  int         cyc = 0;
  logic [3:0] last_mask = '0;

  int         log_w [$];
  int         log_pc [$];
  int         log_cyc [$];
  int         mask_log [$];

  int checks = 0;
  int errors = 0;

  warp_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .base_pc            (base_pc),
    .warp_enable_mask   (warp_enable_mask),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_ready        (fetch_ready),
    .fetch_instruction  (fetch_instruction),
    .instruction        (instruction),
    .dec_mem_read       (dec_mem_read),
    .dec_mem_write      (dec_mem_write),
    .dec_finish         (dec_finish),
    .exec_valid         (exec_valid),
    .exec_branch_taken  (exec_branch_taken),
    .exec_branch_target (exec_branch_target),
    .lsu_start          (lsu_start),
    .lsu_done           (lsu_done),
    .active_warp        (active_warp),
    .warp_done_mask     (warp_done_mask),
    .done               (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Decoder: op in [1:0]; 1 = load, 2 = finish, else ALU.
  assign dec_mem_read  = (instruction[1:0] == 2'd1);
  assign dec_mem_write = 1'b0;
  assign dec_finish    = (instruction[1:0] == 2'd2);

  assign fetch_ready        = ready_on;
  assign exec_branch_taken  = br_en && (active_warp == br_warp);
  assign exec_branch_target = br_target;

  // Fetcher: logs each accepted fetch and drives its word.
  always @(negedge clk) begin
    if (rst_n && fetch_valid && ready_on) begin
      fcount[active_warp]++;
      log_w.push_back(int'(active_warp));
      log_pc.push_back(int'(fetch_pc));
      log_cyc.push_back(cyc);
      if (finish_at != 0 && fcount[active_warp] == finish_at)
        fetch_instruction = 32'd2;
      else if (mem_on && active_warp == mem_warp && fetch_pc == mem_pc)
        fetch_instruction = 32'd1;
      else
        fetch_instruction = 32'd0;
    end
    if (rst_n && warp_done_mask != last_mask) begin
      mask_log.push_back(int'(warp_done_mask));
      last_mask = warp_done_mask;
    end
  end

  // LSU: completes lsu_delay cycles after the issue pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      lsu_wait = 0;
      lsu_done = 1'b0;
    end else if (lsu_start) begin
      lsu_pulses++;
      lsu_wait = lsu_delay;
      lsu_done = 1'b0;
    end else if (lsu_wait > 0) begin
      lsu_wait--;
      lsu_done = (lsu_wait == 0);
    end else begin
      lsu_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_env();
    log_w.delete();
    log_pc.delete();
    log_cyc.delete();
    mask_log.delete();
    for (int i = 0; i < 4; i++) fcount[i] = 0;
    last_mask  = '0;
    lsu_pulses = 0;
    br_en      = 1'b0;
    mem_on     = 1'b0;
    finish_at  = 0;
    lsu_delay  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    clear_env();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic launch(input logic [7:0] b, input logic [3:0] m);
    base_pc          = b;
    warp_enable_mask = m;
    start            = 1'b1;
    tick();
    start            = 1'b0;
  endtask

  task automatic wait_fetch(input int n, input string tag);
    int b = 0;
    while (log_w.size() < n && b < 400) begin
      tick();
      b++;
    end
    check(tag, log_w.size(), n);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_fv", fetch_valid, 0);
    check("rst_ev", exec_valid, 0);
    check("rst_ls", lsu_start, 0);
    check("rst_done", done, 0);
    check("rst_aw", active_warp, 0);
    check("rst_wdm", warp_done_mask, 0);
    check("rst_ins", instruction, 0);
    check("rst_pc", fetch_pc, 0);
    do_reset();

    // Empty mask: done two cycles after start, never fetch
    ready_on = 1'b1;
    launch(8'h10, 4'b0000);
    check("empty_sel", done, 0);
    tick();
    check("empty_done", done, 1);
    tick();
    check("empty_nofetch", log_w.size(), 0);
    check("empty_wdm", warp_done_mask, 4'hf);

    // Relaunch from DONE: ALU-only round robin
    clear_env();
    launch(8'h10, 4'b1111);
    wait_fetch(5, "rr_n");
    if (log_w.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr_w%0d", i), log_w[i], i % 4);
        check($sformatf("rr_pc%0d", i), log_pc[i], i < 4 ? 8'h10 : 8'h11);
      end
      for (int i = 0; i < 4; i++)
        check($sformatf("rr_dt%0d", i), log_cyc[i+1] - log_cyc[i], 5);
    end

    // Branch on warp 1 only
    do_reset();
    br_en     = 1'b1;
    br_warp   = 2'd1;
    br_target = 8'h40;
    launch(8'h10, 4'b1111);
    wait_fetch(8, "br_n");
    if (log_w.size() >= 8) begin
      check("br_w1", log_w[5], 1);
      check("br_pc1", log_pc[5], 8'h40);
      check("br_pc2", log_pc[6], 8'h11);
      check("br_pc3", log_pc[7], 8'h11);
      check("br_pc0", log_pc[4], 8'h11);
    end

    // Load on warp 0, LSU done after 7 cycles
    do_reset();
    mem_on    = 1'b1;
    mem_warp  = 2'd0;
    mem_pc    = 8'h20;
    lsu_delay = 7;
    launch(8'h20, 4'b1111);
    wait_fetch(5, "ld_n");
    if (log_w.size() >= 5) begin
      check("ld_w1", log_w[1], 1);
      check("ld_gap", log_cyc[1] - log_cyc[0], 12);
      check("ld_dt2", log_cyc[2] - log_cyc[1], 5);
      check("ld_pc0", log_pc[4], 8'h21);
    end
    check("ld_pulses", lsu_pulses, 1);

    // Reset while stalled in FETCH
    do_reset();
    ready_on = 1'b0;
    launch(8'h50, 4'b0100);
    begin
      int b = 0;
      while (!fetch_valid && b < 10) begin
        tick();
        b++;
      end
    end
    check("mf_infetch", fetch_valid, 1);
    check("mf_aw2", active_warp, 2);
    rst_n = 1'b0;
    #1;
    check("mf_fv", fetch_valid, 0);
    check("mf_aw", active_warp, 0);
    check("mf_wdm", warp_done_mask, 0);
    check("mf_pc", fetch_pc, 0);
    tick();
    clear_env();
    rst_n    = 1'b1;
    ready_on = 1'b1;
    tick();
    launch(8'h30, 4'b1111);
    wait_fetch(1, "mf_n");
    if (log_w.size() >= 1) begin
      check("mf_w", log_w[0], 0);
      check("mf_rpc", log_pc[0], 8'h30);
    end

    // Finish on third instruction, warps 0 and 2 enabled
    do_reset();
    finish_at = 3;
    launch(8'h00, 4'b0101);
    begin
      int b = 0;
      while (!done && b < 200) begin
        tick();
        b++;
      end
    end
    check("fin_done", done, 1);
    check("fin_nf", log_w.size(), 6);
    check("fin_nm", mask_log.size(), 3);
    if (mask_log.size() >= 3) begin
      check("fin_m0", mask_log[0], 4'b1010);
      check("fin_m1", mask_log[1], 4'b1011);
      check("fin_m2", mask_log[2], 4'b1111);
    end
    begin
      int bad = 0;
      foreach (log_w[i]) if (log_w[i] == 1 || log_w[i] == 3) bad++;
      check("fin_odd", bad, 0);
    end
    if (log_w.size() >= 5) check("fin_pc", log_pc[4], 8'h02);

    // PC wrap at 0xFF
    do_reset();
    launch(8'hff, 4'b0001);
    wait_fetch(2, "wr_n");
    if (log_w.size() >= 2) begin
      check("wr_pc0", log_pc[0], 8'hff);
      check("wr_pc1", log_pc[1], 8'h00);
      check("wr_dt", log_cyc[1] - log_cyc[0], 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
